// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout, forward-select codes and
// the operand-forwarding priority rule, reused by every inter-stage register.
package id_ex_stage_pkg;

    localparam int CTRL_W     = 8;
    localparam int REG_ADDR_W = 5;

    // Control bundle bit positions, MSB first.
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // What a pipeline register does on the coming edge, highest priority first.
    typedef enum logic [1:0] {
        XFER_FLUSH   = 2'd0,
        XFER_HOLD    = 2'd1,
        XFER_BUBBLE  = 2'd2,
        XFER_CAPTURE = 2'd3
    } xfer_e;

    // The youngest in-flight writer wins; register 0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic                  consumer_valid,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  exmem_we,
        input logic [REG_ADDR_W-1:0] exmem_rd,
        input logic                  memwb_we,
        input logic [REG_ADDR_W-1:0] memwb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (consumer_valid && (src != '0)) begin
            if (exmem_we && (exmem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_we && (memwb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_forward_unit.sv
// Load-use hazard detection for the instruction in ID and operand-forward
// selection for the instruction in EX. Purely combinational.
module hazard_forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  hold,
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    output logic                  load_use,
    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path can infer a latch.
        load_use = 1'b0;
        if (id_valid && ex_valid && ex_memread && (ex_dest != '0) &&
            ((ex_dest == id_rs) || (ex_dest == id_rt))) begin
            load_use = 1'b1;
        end
    end

    assign stall = load_use | hold;

    assign fwd_a = fwd_select(ex_valid, ex_rs, exmem_regwrite, exmem_rd,
                              memwb_regwrite, memwb_rd);
    assign fwd_b = fwd_select(ex_valid, ex_rt, exmem_regwrite, exmem_rd,
                              memwb_regwrite, memwb_rd);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/bubble control, load-use stall
// generation, forwarding selects and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_readdata1,
    input  logic [DATA_W-1:0] id_readdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              hold,
    input  logic              exmem_regwrite,
    input  logic [4:0]        exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [4:0]        memwb_rd,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_readdata1,
    output logic [DATA_W-1:0] ex_readdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [15:0]       bubble_count
);

    logic              ex_valid_q,     ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
    logic [4:0]        ex_rs_q,        ex_rs_d;
    logic [4:0]        ex_rt_q,        ex_rt_d;
    logic [4:0]        ex_dest_q,      ex_dest_d;
    logic [DATA_W-1:0] ex_readdata1_q, ex_readdata1_d;
    logic [DATA_W-1:0] ex_readdata2_q, ex_readdata2_d;
    logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
    logic [15:0]       bubble_count_q, bubble_count_d;

    logic  load_use;
    xfer_e xfer;

    hazard_forward_unit u_hazard_forward_unit (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .hold           (hold),
        .ex_valid       (ex_valid_q),
        .ex_memread     (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rs          (ex_rs_q),
        .ex_rt          (ex_rt_q),
        .ex_dest        (ex_dest_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .load_use       (load_use),
        .stall          (stall),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    always_comb begin
        if (flush) begin
            xfer = XFER_FLUSH;
        end else if (hold) begin
            xfer = XFER_HOLD;
        end else if (load_use) begin
            xfer = XFER_BUBBLE;
        end else begin
            xfer = XFER_CAPTURE;
        end
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        ex_readdata1_d = ex_readdata1_q;
        ex_readdata2_d = ex_readdata2_q;
        ex_imm_d       = ex_imm_q;
        bubble_count_d = bubble_count_q;

        case (xfer)
            // A flushed slot and a load-use bubble both leave an empty, zeroed EX stage.
            XFER_FLUSH, XFER_BUBBLE: begin
                ex_valid_d     = 1'b0;
                ex_ctrl_d      = '0;
                ex_rs_d        = '0;
                ex_rt_d        = '0;
                ex_dest_d      = '0;
                ex_readdata1_d = '0;
                ex_readdata2_d = '0;
                ex_imm_d       = '0;
            end
            XFER_CAPTURE: begin
                ex_valid_d     = id_valid;
                ex_ctrl_d      = id_valid ? id_ctrl : '0;
                ex_rs_d        = id_rs;
                ex_rt_d        = id_rt;
                ex_dest_d      = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
                ex_readdata1_d = id_readdata1;
                ex_readdata2_d = id_readdata2;
                ex_imm_d       = id_imm;
            end
            default: begin
            end
        endcase

        if ((xfer == XFER_BUBBLE) && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_readdata1_q <= '0;
            ex_readdata2_q <= '0;
            ex_imm_q       <= '0;
            bubble_count_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_readdata1_q <= ex_readdata1_d;
            ex_readdata2_q <= ex_readdata2_d;
            ex_imm_q       <= ex_imm_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_readdata1 = ex_readdata1_q;
    assign ex_readdata2 = ex_readdata2_q;
    assign ex_imm       = ex_imm_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model of
// the ID/EX transfer rules, hazard detection and forwarding.
module tb_id_ex_stage;

    localparam logic [7:0] LW_CTRL = 8'hD8;  // regwrite, memread, memtoreg, alusrc
    localparam logic [7:0] R_CTRL  = 8'h86;  // regwrite, regdst, aluop=10

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_readdata1, id_readdata2, id_imm;
    logic [7:0]  id_ctrl;
    logic        flush, hold;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        stall, ex_valid;
    logic [7:0]  ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [31:0] ex_readdata1, ex_readdata2, ex_imm;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of what the EX stage should hold.
    bit          m_valid;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_rd1, m_rd2, m_imm;
    int          m_bub;
    bit          m_data_known;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_readdata1   (id_readdata1),
        .id_readdata2   (id_readdata2),
        .id_imm         (id_imm),
        .id_ctrl        (id_ctrl),
        .flush          (flush),
        .hold           (hold),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_ctrl        (ex_ctrl),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_dest        (ex_dest),
        .ex_readdata1   (ex_readdata1),
        .ex_readdata2   (ex_readdata2),
        .ex_imm         (ex_imm),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .bubble_count   (bubble_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        return id_valid && m_valid && m_ctrl[6] && (m_dest != 5'd0) &&
               ((m_dest == id_rs) || (m_dest == id_rt));
    endfunction

    // Which downstream stage holds the newest value of register r.
    function automatic logic [1:0] model_fwd(input logic [4:0] r);
        if (!m_valid || r == 5'd0) return 2'b00;
        if (exmem_regwrite && exmem_rd == r) return 2'b10;
        if (memwb_regwrite && memwb_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_dest = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_bub = 0; m_data_known = 1;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_dest = 0;
            m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_data_known = 1;
        end else if (hold) begin
            // contents kept
        end else if (model_load_use()) begin
            m_valid = 0; m_ctrl = 0; m_data_known = 0;
            m_bub = (m_bub >= 65535) ? 65535 : m_bub + 1;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : 8'h00;
            m_rs = id_rs; m_rt = id_rt;
            m_dest = id_ctrl[2] ? id_rd : id_rt;
            m_rd1 = id_readdata1; m_rd2 = id_readdata2; m_imm = id_imm;
            m_data_known = 1;
        end
    endtask

    task automatic check_comb(input string t);
        check({t, ":stall"}, stall, model_load_use() || hold);
        check({t, ":fwd_a"}, fwd_a, model_fwd(m_rs));
        check({t, ":fwd_b"}, fwd_b, model_fwd(m_rt));
    endtask

    task automatic check_regs(input string t);
        check({t, ":ex_valid"}, ex_valid, m_valid);
        check({t, ":ex_ctrl"}, ex_ctrl, m_ctrl);
        check({t, ":bubble_count"}, bubble_count, m_bub);
        if (m_data_known) begin
            check({t, ":ex_rs"}, ex_rs, m_rs);
            check({t, ":ex_rt"}, ex_rt, m_rt);
            check({t, ":ex_dest"}, ex_dest, m_dest);
            check({t, ":ex_readdata1"}, ex_readdata1, m_rd1);
            check({t, ":ex_readdata2"}, ex_readdata2, m_rd2);
            check({t, ":ex_imm"}, ex_imm, m_imm);
        end
    endtask

    task automatic check_all_zero(input string t);
        check({t, ":ex_valid"}, ex_valid, 0);
        check({t, ":ex_ctrl"}, ex_ctrl, 0);
        check({t, ":ex_rs"}, ex_rs, 0);
        check({t, ":ex_rt"}, ex_rt, 0);
        check({t, ":ex_dest"}, ex_dest, 0);
        check({t, ":ex_readdata1"}, ex_readdata1, 0);
        check({t, ":ex_readdata2"}, ex_readdata2, 0);
        check({t, ":ex_imm"}, ex_imm, 0);
        check({t, ":bubble_count"}, bubble_count, 0);
        check({t, ":stall"}, stall, 0);
        check({t, ":fwd_a"}, fwd_a, 0);
        check({t, ":fwd_b"}, fwd_b, 0);
    endtask

    // One clock: combinational checks mid-cycle, registered checks just after the edge.
    task automatic cycle(input string t);
        @(negedge clock);
        check_comb(t);
        @(posedge clock);
        model_edge();
        #1;
        check_regs(t);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [7:0] ctrl,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
        id_readdata1 = d1; id_readdata2 = d2; id_imm = imm;
    endtask

    initial begin
        reset_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0; hold = 0;
        exmem_regwrite = 0; exmem_rd = 0; memwb_regwrite = 0; memwb_rd = 0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        cycle("idle");

        // Load-use: lw $2 then a consumer of $2.
        set_id(1, 5'd1, 5'd2, 5'd0, LW_CTRL, 32'h11, 32'h22, 32'h4);
        cycle("lw2");
        set_id(1, 5'd2, 5'd3, 5'd4, R_CTRL, 32'hA1, 32'hA2, 32'h0);
        cycle("lu_bubble");
        check("lu_bubble:count_is_1", bubble_count, 16'd1);
        cycle("lu_capture");
        check("lu_capture:valid", ex_valid, 1'b1);

        // Forwarding priority on ex_rs=5.
        set_id(1, 5'd5, 5'd6, 5'd7, R_CTRL, 32'h55, 32'h66, 32'h0);
        cycle("fwd_setup");
        hold = 1; exmem_regwrite = 1; exmem_rd = 5'd5; memwb_regwrite = 1; memwb_rd = 5'd5;
        #1;
        check("fwd:exmem_wins", fwd_a, 2'b10);
        cycle("fwd_both");
        exmem_regwrite = 0;
        #1;
        check("fwd:memwb_only", fwd_a, 2'b01);
        cycle("fwd_memwb");
        hold = 0; memwb_regwrite = 0;

        // Register 0 never hazards or forwards.
        set_id(1, 5'd1, 5'd0, 5'd0, LW_CTRL, 32'h1, 32'h2, 32'h3);
        cycle("lw0");
        set_id(1, 5'd0, 5'd0, 5'd0, R_CTRL, 32'h7, 32'h8, 32'h0);
        exmem_regwrite = 1; exmem_rd = 5'd0;
        cycle("r0_no_stall");
        check("r0:fwd_b", fwd_b, 2'b00);
        check("r0:no_bubble", bubble_count, 16'd1);
        exmem_regwrite = 0;

        // flush beats hold beats load-use.
        set_id(1, 5'd1, 5'd3, 5'd0, LW_CTRL, 32'h1, 32'h2, 32'h3);
        cycle("lw3");
        set_id(1, 5'd3, 5'd4, 5'd5, R_CTRL, 32'h9, 32'h9, 32'h0);
        flush = 1; hold = 1;
        cycle("flush_prio");
        check("flush_prio:bubble_unchanged", bubble_count, 16'd1);
        flush = 0; hold = 0;

        // hold for three cycles.
        set_id(1, 5'd8, 5'd9, 5'd10, R_CTRL, 32'hDEADBEEF, 32'h12345678, 32'h0);
        cycle("hold_load");
        hold = 1;
        set_id(1, 5'd11, 5'd12, 5'd13, R_CTRL, 32'hCAFEF00D, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold");
            check("hold:rd1_stable", ex_readdata1, 32'hDEADBEEF);
        end
        hold = 0;
        cycle("hold_release");
        check("hold_release:rd1", ex_readdata1, 32'hCAFEF00D);

        // Saturation of bubble_count.
        hold = 1;
        force dut.bubble_count_q = 16'hFFFE;
        m_bub = 16'hFFFE;
        cycle("preload");
        release dut.bubble_count_q;
        #1;
        check("preload:count", bubble_count, 16'hFFFE);
        hold = 0;
        set_id(1, 5'd9, 5'd9, 5'd0, LW_CTRL, 32'h1, 32'h2, 32'h3);
        for (int i = 0; i < 3; i++) begin
            cycle("sat_capture");
            cycle("sat_bubble");
        end
        check("sat:count", bubble_count, 16'hFFFF);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        reset_n = 1'b1;

        // Reset arriving mid-stall discards the bubble.
        cycle("pre_stall_lw");
        #1;
        check("mid_stall:stall", stall, 1'b1);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        model_reset();
        cycle("post_reset_capture");
        check("post_reset_capture:valid", ex_valid, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   8'($urandom), $urandom, $urandom, $urandom);
            flush          = ($urandom_range(0, 15) == 0);
            hold           = ($urandom_range(0, 7) == 0);
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 7));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
